// File: rtl/key_expansion_seq_if.sv
// Handshake/bus bundle for key_expansion_seq.
//   start : request expansion of key (driven by master)
//   key   : cipher key, word 0 in the top 32 bits (driven by master)
//   w     : flattened round-key bus, round key r at w[r*128 +: 128] (driven by slave)
//   busy  : expansion in progress (driven by slave)
//   done  : one-cycle completion pulse (driven by slave)
interface key_expansion_seq_if #(
  parameter int Nk = 4,
  parameter int Nr = 10
);
  logic                    start;
  logic [32*Nk-1:0]        key;
  logic [128*(Nr+1)-1:0]   w;
  logic                    busy;
  logic                    done;

  modport master (output start, output key, input w, input busy, input done);
  modport slave  (input start, input key, output w, output busy, output done);
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule: loads a key on start and derives one 32-bit
// schedule word per clock until all Nr+1 round keys are present on bus.w.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of key_expansion_seq_if (start/key in, w/busy/done out)
module key_expansion_seq #(
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_expansion_seq_if.slave   bus
);

  localparam int unsigned NW = 4 * (Nr + 1);
  localparam int unsigned IW = $clog2(NW + 1);
  localparam int unsigned PW = $clog2(Nk);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    words [NW];
  logic [IW-1:0]  idx_q;
  // Tracks i mod Nk so AES-192 needs no divider.
  logic [PW-1:0]  phase_q;
  logic [7:0]     rcon_q;

  logic [31:0]    prev_word, base_word, temp_word, new_word;
  logic           last_word;
  logic [128*(Nr+1)-1:0] w_flat;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned n = 1; n < 8; n++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  always_comb begin
    prev_word = words[idx_q - IW'(1)];
    base_word = words[idx_q - IW'(Nk)];
    temp_word = prev_word;
    if (phase_q == '0)
      temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon_q, 24'h0};
    else if (Nk == 8 && phase_q == PW'(4))
      temp_word = sub_word(prev_word);
    new_word  = base_word ^ temp_word;
    last_word = (idx_q == IW'(NW - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = EXPAND;
      EXPAND:  if (last_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < NW; n++) words[n] <= '0;
      idx_q   <= '0;
      phase_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            for (int unsigned k = 0; k < Nk; k++)
              words[k] <= bus.key[32*(Nk-k)-1 -: 32];
            idx_q   <= IW'(Nk);
            phase_q <= '0;
            rcon_q  <= 8'h01;
          end
        end
        EXPAND: begin
          words[idx_q] <= new_word;
          if (phase_q == '0)
            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          if (!last_word) idx_q <= idx_q + 1'b1;
          phase_q <= (phase_q == PW'(Nk - 1)) ? '0 : phase_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Word 4r+c sits at round-key slot r, column c counted from the MSB end.
  always_comb begin
    w_flat = '0;
    for (int unsigned j = 0; j < NW; j++)
      w_flat[(j/4)*128 + (3 - (j%4))*32 +: 32] = words[j];
  end

  assign bus.w    = w_flat;
  assign bus.busy = (state_q == EXPAND);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_key_expansion_seq.sv
module tb_key_expansion_seq;

  localparam int NK128 = 4, NR128 = 10;
  localparam int NK192 = 6, NR192 = 12;
  localparam int NK256 = 8, NR256 = 14;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_expansion_seq_if #(.Nk(NK128), .Nr(NR128)) if128();
  key_expansion_seq_if #(.Nk(NK192), .Nr(NR192)) if192();
  key_expansion_seq_if #(.Nk(NK256), .Nr(NR256)) if256();

  key_expansion_seq #(.Nr(NR128), .Nk(NK128)) dut128 (.clk(clk), .rst_n(rst_n), .bus(if128));
  key_expansion_seq #(.Nr(NR192), .Nk(NK192)) dut192 (.clk(clk), .rst_n(rst_n), .bus(if192));
  key_expansion_seq #(.Nr(NR256), .Nk(NK256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(if256));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          d;
    int          j;
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sb[$];

  function automatic bit legal_cfg(input int nk, input int nr);
    return (nk == 4 && nr == 10) || (nk == 6 && nr == 12) || (nk == 8 && nr == 14);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_word(input int d, input int j);
    int b;
    b = (j / 4) * 128 + (3 - (j % 4)) * 32;
    case (d)
      0:       return if128.w[b +: 32];
      1:       return if192.w[b +: 32];
      default: return if256.w[b +: 32];
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0:       return if128.done;
      1:       return if192.done;
      default: return if256.done;
    endcase
  endfunction

  task automatic push(input int d, input int j, input logic [31:0] e, input string tag);
    sb_t s;
    s.d = d; s.j = j; s.exp = e; s.tag = tag;
    sb.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      check(s.tag, 128'(get_word(s.d, s.j)), 128'(s.exp));
    end
  endtask

  // Called on the sample right after the start edge (cycle 1).
  task automatic wait_done(input int d, output int cyc);
    cyc = 1;
    for (int n = 0; n < 200; n++) begin
      if (get_done(d)) return;
      tick();
      cyc++;
    end
    cyc = -1;
  endtask

  task automatic push_fips128();
    push(0, 4,  32'ha0fafe17, "k128_w4");
    push(0, 5,  32'h88542cb1, "k128_w5");
    push(0, 6,  32'h23a33939, "k128_w6");
    push(0, 7,  32'h2a6c7605, "k128_w7");
    push(0, 8,  32'hf2c295f2, "k128_w8");
    push(0, 9,  32'h7a96b943, "k128_w9");
    push(0, 10, 32'h5935807a, "k128_w10");
    push(0, 11, 32'h7359f67f, "k128_w11");
    push(0, 40, 32'hd014f9a8, "k128_w40");
    push(0, 41, 32'hc9ee2589, "k128_w41");
    push(0, 42, 32'he13f0cc8, "k128_w42");
    push(0, 43, 32'hb6630ca6, "k128_w43");
  endtask

  initial begin
    int cyc;
    int ndone;
    int first_done;
    logic [255:0] kv;

    assert (legal_cfg(NK128, NR128) && legal_cfg(NK192, NR192) && legal_cfg(NK256, NR256))
      else $fatal(1, "FAIL cfg illegal Nk/Nr pair");

    // Reset with start held high.
    rst_n = 1'b0;
    if128.start = 1'b1; if192.start = 1'b1; if256.start = 1'b1;
    if128.key = K128;   if192.key = K192;   if256.key = K256;
    tick(); tick();
    check("rst_w128",  128'(|if128.w), 128'd0);
    check("rst_w192",  128'(|if192.w), 128'd0);
    check("rst_w256",  128'(|if256.w), 128'd0);
    check("rst_busy",  128'({if128.busy, if192.busy, if256.busy}), 128'd0);
    check("rst_done",  128'({if128.done, if192.done, if256.done}), 128'd0);

    rst_n = 1'b1;
    if128.start = 1'b0; if192.start = 1'b0; if256.start = 1'b0;
    tick();
    check("rel_w128",  128'(|if128.w), 128'd0);
    check("rel_busy",  128'(if128.busy), 128'd0);
    check("rel_done",  128'(if128.done), 128'd0);

    // AES-128 directed vector.
    kv = 256'(K128);
    for (int k = 0; k < NK128; k++) push(0, k, kv[32*(NK128-k)-1 -: 32], "k128_key_word");
    push_fips128();
    if128.start = 1'b1;
    tick();
    if128.start = 1'b0;
    check("k128_busy_c1", 128'(if128.busy), 128'd1);
    wait_done(0, cyc);
    check("k128_done_cycle", 128'(cyc), 128'd41);
    check("k128_busy_at_done", 128'(if128.busy), 128'd0);
    drain();
    check("k128_rk10", if128.w[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("k128_rk0",  if128.w[0 +: 128], K128);
    tick();
    check("k128_done_single", 128'(if128.done), 128'd0);

    // AES-192 directed vector.
    kv = 256'(K192);
    for (int k = 0; k < NK192; k++) push(1, k, kv[32*(NK192-k)-1 -: 32], "k192_key_word");
    push(1, 6,  32'hfe0c91f7, "k192_w6");
    push(1, 51, 32'h01002202, "k192_w51");
    if192.start = 1'b1;
    tick();
    if192.start = 1'b0;
    check("k192_busy_c1", 128'(if192.busy), 128'd1);
    wait_done(1, cyc);
    check("k192_done_cycle", 128'(cyc), 128'd47);
    drain();
    tick();
    check("k192_done_single", 128'(if192.done), 128'd0);

    // AES-256 directed vector.
    kv = K256;
    for (int k = 0; k < NK256; k++) push(2, k, kv[32*(NK256-k)-1 -: 32], "k256_key_word");
    push(2, 8,  32'h9ba35411, "k256_w8");
    push(2, 12, 32'ha8b09c1a, "k256_w12");
    push(2, 59, 32'h706c631e, "k256_w59");
    if256.start = 1'b1;
    tick();
    if256.start = 1'b0;
    wait_done(2, cyc);
    check("k256_done_cycle", 128'(cyc), 128'd53);
    drain();
    tick();
    check("k256_done_single", 128'(if256.done), 128'd0);

    // Start pulses and key changes while busy must not disturb the expansion.
    push_fips128();
    if128.key = K128;
    if128.start = 1'b1;
    tick();
    cyc = 1; ndone = 0; first_done = -1;
    for (int n = 0; n < 60; n++) begin
      if (if128.done) begin
        ndone++;
        if (first_done < 0) first_done = cyc;
      end
      if (cyc == 5 || cyc == 20) begin
        if128.start = 1'b1;
        if128.key   = ~K128;
      end else begin
        if128.start = 1'b0;
      end
      tick();
      cyc++;
    end
    check("busy_start_done_count", 128'(ndone), 128'd1);
    check("busy_start_done_cycle", 128'(first_done), 128'd41);
    drain();

    // Start in the DONE cycle is ignored; start in the next IDLE cycle is taken.
    if128.key = K128;
    if128.start = 1'b1;
    tick();
    if128.start = 1'b0;
    wait_done(0, cyc);
    check("b2b_first_done_cycle", 128'(cyc), 128'd41);
    if128.key   = '0;
    if128.start = 1'b1;
    tick();
    check("done_start_ignored_busy", 128'(if128.busy), 128'd0);
    check("done_start_ignored_w43",  128'(get_word(0, 43)), 128'(32'hb6630ca6));
    tick();
    if128.start = 1'b0;
    check("idle_start_busy", 128'(if128.busy), 128'd1);
    check("idle_start_w0",   128'(get_word(0, 0)), 128'd0);
    wait_done(0, cyc);
    check("zero_key_done_cycle", 128'(cyc), 128'd41);
    push(0, 4,  32'h62636363, "zk_w4");
    push(0, 7,  32'h62636363, "zk_w7");
    push(0, 8,  32'h9b9898c9, "zk_w8");
    push(0, 9,  32'hf9fbfbaa, "zk_w9");
    push(0, 10, 32'h9b9898c9, "zk_w10");
    push(0, 11, 32'hf9fbfbaa, "zk_w11");
    drain();
    tick();

    // Reset in the middle of an expansion.
    if128.key = K128;
    if128.start = 1'b1;
    tick();
    if128.start = 1'b0;
    cyc = 1;
    while (cyc < 17) begin
      tick();
      cyc++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_w",    128'(|if128.w), 128'd0);
    check("midrst_busy", 128'(if128.busy), 128'd0);
    check("midrst_done", 128'(if128.done), 128'd0);
    ndone = 0;
    for (int n = 0; n < 50; n++) begin
      if (if128.done) ndone++;
      tick();
    end
    check("midrst_no_done", 128'(ndone), 128'd0);
    push_fips128();
    if128.start = 1'b1;
    tick();
    if128.start = 1'b0;
    wait_done(0, cyc);
    check("after_rst_done_cycle", 128'(cyc), 128'd41);
    drain();
    check("after_rst_rk10", if128.w[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
